ifetch32: RTL and testbench

//  Instruction fetch unit; the producer side of the decoder's instruction input (iin).

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/ifetch32.sv | 104 ++++++++++
 tb/tb_ifetch32.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch FSM states and the queue entry bundle.
// Imported by the fetch unit and its queue.
package cpu_pkg;

    localparam int INSN_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous in-order queue with flush.
// Head is read straight from registered storage.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch32.sv
// ifetch32: PC, single-outstanding req/gnt fetch and redirect handling.
// Fetched words reach the decoder through fetch_fifo.
module ifetch32
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INSN_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;

    // A request is only issued while a slot is free for its response.
    assign imem_req  = (state == S_FETCH) && (count < DEPTH_C);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req & imem_gnt;
    assign push      = (state == S_WAIT) & imem_rvalid & ~branch_valid;
    assign pop       = inst_valid & inst_ready;

    assign wr_entry.insn = imem_rdata;
    assign wr_entry.pc   = req_pc;

    assign inst_valid = ~empty;
    assign inst_out   = empty ? '0 : head.insn;
    assign pc_out     = empty ? '0 : head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push & ~full),
        .pop   (pop),
        .flush (branch_valid),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  state_nx = S_FETCH;
            S_FETCH: begin
                if (accept)
                    state_nx = branch_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid)       state_nx = S_FETCH;
                else if (branch_valid) state_nx = S_DROP;
            end
            S_DROP: begin
                if (imem_rvalid) state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state <= state_nx;
            if (accept) req_pc <= fetch_pc;
            if (branch_valid)
                fetch_pc <= branch_target & ~32'h3;
            else if (accept)
                fetch_pc <= fetch_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_ifetch32.sv
// tb_ifetch32: randomized scoreboard bench for the fetch unit.
// Expected stream: consecutive word addresses restarting at each redirect.
module tb_ifetch32;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    always #5 clk = ~clk;

    ifetch32 #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .pc_out        (pc_out)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;
    logic [31:0] mon_e;

    bit          pend;
    logic [31:0] pend_addr;
    int          pend_dly;
    int          dly_lo, dly_hi;
    int          gnt_pct, rdy_pct;
    bit          rst_req;
    int          br_mode;
    logic [31:0] br_tgt;
    bit          br_fired;
    int          accepts;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic timeout(string n);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", n);
    endtask

    // One cycle: memory model and inputs at negedge, model update before posedge.
    task automatic step();
        @(negedge clk);
        rst_n = !rst_req;
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        if (pend) begin
            if (pend_dly <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                pend_dly--;
            end
        end
        imem_gnt = rst_n && ($urandom_range(1, 100) <= gnt_pct);
        inst_ready = ($urandom_range(1, 100) <= rdy_pct);
        branch_valid = 1'b0;
        branch_target = $urandom;
        #1;
        if (rst_n && br_mode != 0) begin
            if (br_mode == 1 ||
                (br_mode == 2 && imem_req && imem_gnt) ||
                (br_mode == 3 && imem_rvalid)) begin
                branch_valid = 1'b1;
                branch_target = br_tgt;
                br_mode = 0;
                br_fired = 1'b1;
            end
        end
        #2;
        if (!rst_n) begin
            exp_q.delete();
            next_pc = RESET_PC;
        end else begin
            if (imem_req && imem_gnt) begin
                chk("fetch_addr", imem_addr, next_pc);
                exp_q.push_back(next_pc);
                next_pc = next_pc + 32'd4;
                pend = 1'b1;
                pend_addr = imem_addr;
                pend_dly = $urandom_range(dly_lo, dly_hi);
                accepts++;
            end
            if (branch_valid) begin
                exp_q.delete();
                next_pc = branch_target & ~32'h3;
            end
        end
    endtask

    // Monitor: every pop must be the next expected address and its word.
    always @(negedge clk) begin
        #2;
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected none", pc_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_pc", pc_out, mon_e);
                chk("pop_insn", inst_out, mem_word(mon_e));
            end
        end
    end

    task automatic arm_branch(int mode, logic [31:0] tgt, string n);
        bit ok;
        ok = 1'b0;
        br_mode = mode;
        br_tgt = tgt;
        br_fired = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (br_fired) begin
                ok = 1'b1;
                break;
            end
        end
        br_mode = 0;
        if (!ok) timeout(n);
    endtask

    task automatic wait_accept(string n);
        int a0;
        a0 = accepts;
        for (int i = 0; i < 40; i++) begin
            step();
            if (accepts != a0) break;
        end
        if (accepts == a0) timeout(n);
    endtask

    task automatic expect_visible(string n, logic [31:0] pc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (inst_valid) begin
                chk(n, pc_out, pc);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(n);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, RESET_PC);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"}, inst_out, 32'd0);
        chk({tag, "_pc"}, pc_out, 32'd0);
    endtask

    initial begin
        int lat;
        int a0;
        logic [31:0] seen [3];
        int ns;

        rst_n = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        branch_valid = 1'b0;
        branch_target = '0;
        inst_ready = 1'b0;
        pend = 1'b0;
        pend_addr = '0;
        pend_dly = 0;
        accepts = 0;
        br_mode = 0;
        br_tgt = '0;
        br_fired = 1'b0;
        next_pc = RESET_PC;
        dly_lo = 1;
        dly_hi = 1;
        gnt_pct = 100;
        rdy_pct = 100;

        rst_req = 1'b1;
        step();
        step();
        check_reset_outputs("reset");

        // Streaming after reset release.
        rst_req = 1'b0;
        step();
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (inst_valid) begin
                lat = n;
                break;
            end
        end
        chk("first_valid_latency", lat, 3);
        repeat (20) step();

        // Decoder stalls: queue fills, requests stop.
        rdy_pct = 0;
        repeat (12) step();
        chk("held_entries", exp_q.size(), 2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
        end
        a0 = accepts;
        rdy_pct = 100;
        repeat (20) step();
        chk("resume_fetch", {31'd0, accepts > a0}, 32'd1);

        // Redirect while a response is outstanding.
        dly_lo = 3;
        dly_hi = 3;
        wait_accept("t3_accept");
        dly_lo = 1;
        dly_hi = 1;
        br_mode = 1;
        br_tgt = 32'h0000_0103;
        br_fired = 1'b0;
        step();
        chk("t3_fired", {31'd0, br_fired}, 32'd1);
        step();
        chk("t3_valid_after_branch", {31'd0, inst_valid}, 32'd0);
        expect_visible("t3_first_pc", 32'h0000_0100);
        repeat (6) step();

        // Redirect on accept, then redirect on response.
        arm_branch(2, 32'h0000_0200, "t4_branch_accept");
        wait_accept("t4_refetch");
        arm_branch(3, 32'h0000_0300, "t4_branch_rvalid");
        expect_visible("t4_first_pc", 32'h0000_0300);
        repeat (6) step();

        // Address wrap at the top of the space.
        arm_branch(1, 32'hFFFF_FFF8, "t5_branch");
        ns = 0;
        for (int i = 0; i < 40 && ns < 3; i++) begin
            step();
            if (inst_valid && inst_ready) begin
                seen[ns] = pc_out;
                ns++;
            end
        end
        if (ns < 3) timeout("t5_stream");
        else begin
            chk("t5_pc0", seen[0], 32'hFFFF_FFF8);
            chk("t5_pc1", seen[1], 32'hFFFF_FFFC);
            chk("t5_wrap", seen[2], 32'h0000_0000);
        end

        // Reset with a response still pending; it lands after reset.
        dly_lo = 2;
        dly_hi = 2;
        wait_accept("t6_accept");
        dly_lo = 1;
        dly_hi = 1;
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("t6_stale_rvalid", {31'd0, imem_rvalid}, 32'd1);
        check_reset_outputs("t6");
        expect_visible("t6_refetch_pc", RESET_PC);

        // Randomized traffic with random redirects.
        dly_lo = 1;
        dly_hi = 3;
        gnt_pct = 60;
        rdy_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            if (br_mode == 0 && $urandom_range(0, 99) < 4) begin
                br_mode = $urandom_range(1, 3);
                br_tgt = $urandom & 32'h000F_FFFF;
            end
            step();
        end
        br_mode = 0;
        gnt_pct = 100;
        rdy_pct = 100;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
